// File: rtl/snake_head_stepper.sv
// Snake head stepper: debounced buttons steer the head across a COLS x ROWS board, one cell per game tick.
// Define SNAKE_WRAP_EN to wrap at the board edges; otherwise leaving the board ends the game (DEAD).
module snake_head_stepper #(
  parameter int COLS       = 32,
  parameter int ROWS       = 24,
  parameter int TICK_DIV   = 5000000,
  parameter int DEB_CYCLES = 250000
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic [31:0] oRow,
  output logic [31:0] oCol,
  output logic [31:0] oBoardPosition,
  output logic [1:0]  oDir,
  output logic        oStep,
  output logic        oDead
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [31:0] ROW_HOME = 32'(ROWS / 2);
  localparam logic [31:0] COL_HOME = 32'(COLS / 2);
  localparam logic [31:0] POS_HOME = 32'((ROWS / 2) * COLS + (COLS / 2));

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } state_t;

  state_t          state_r;
  logic [TW-1:0]   tickCnt_r;
  logic [1:0]      pending_r;

  logic [3:0]      btnRaw_s;
  logic [3:0]      sync1_r;
  logic [3:0]      sync2_r;
  logic [3:0]      deb_r;
  logic [3:0]      debD_r;
  logic [DW-1:0]   debCnt_r [4];
  logic [3:0]      press_s;

  logic            pressValid_s;
  logic [1:0]      pressDir_s;
  logic            accept_s;
  logic            tick_s;

  logic [31:0]     nextRow_s;
  logic [31:0]     nextCol_s;
  logic [31:0]     nextPos_s;
  logic            offBoard_s;

  // Bit order follows press priority: up, down, left, right.
  assign btnRaw_s = {up, down, left, right};
  assign press_s  = deb_r & ~debD_r;

  // Two-flop synchronizers plus per-button stability counters.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      deb_r   <= 4'b0000;
      debD_r  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        debCnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      sync1_r <= btnRaw_s;
      sync2_r <= sync1_r;
      debD_r  <= deb_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          debCnt_r[i] <= {DW{1'b0}};
        end else if (debCnt_r[i] == DW'(DEB_CYCLES - 1)) begin
          deb_r[i]    <= sync2_r[i];
          debCnt_r[i] <= {DW{1'b0}};
        end else begin
          debCnt_r[i] <= debCnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Priority select among simultaneous presses.
  always_comb begin
    pressValid_s = 1'b0;
    pressDir_s   = DIR_RIGHT;
    if (press_s[3]) begin
      pressValid_s = 1'b1;
      pressDir_s   = DIR_UP;
    end else if (press_s[2]) begin
      pressValid_s = 1'b1;
      pressDir_s   = DIR_DOWN;
    end else if (press_s[1]) begin
      pressValid_s = 1'b1;
      pressDir_s   = DIR_LEFT;
    end else if (press_s[0]) begin
      pressValid_s = 1'b1;
      pressDir_s   = DIR_RIGHT;
    end else begin
      pressValid_s = 1'b0;
      pressDir_s   = DIR_RIGHT;
    end
  end

  // Flipping bit 1 of a direction code yields its opposite.
  assign accept_s = pressValid_s && (pressDir_s != (oDir ^ 2'b10));
  assign tick_s   = (state_r == RUN) && (tickCnt_r == TW'(TICK_DIV - 1));

  // Candidate head position for the pending direction.
  always_comb begin
    nextRow_s  = oRow;
    nextCol_s  = oCol;
    offBoard_s = 1'b0;
    case (pending_r)
      DIR_RIGHT: begin
        if (oCol == 32'(COLS - 1)) begin
`ifdef SNAKE_WRAP_EN
          nextCol_s = 32'd0;
`else
          offBoard_s = 1'b1;
`endif
        end else begin
          nextCol_s = oCol + 32'd1;
        end
      end
      DIR_LEFT: begin
        if (oCol == 32'd0) begin
`ifdef SNAKE_WRAP_EN
          nextCol_s = 32'(COLS - 1);
`else
          offBoard_s = 1'b1;
`endif
        end else begin
          nextCol_s = oCol - 32'd1;
        end
      end
      DIR_DOWN: begin
        if (oRow == 32'(ROWS - 1)) begin
`ifdef SNAKE_WRAP_EN
          nextRow_s = 32'd0;
`else
          offBoard_s = 1'b1;
`endif
        end else begin
          nextRow_s = oRow + 32'd1;
        end
      end
      DIR_UP: begin
        if (oRow == 32'd0) begin
`ifdef SNAKE_WRAP_EN
          nextRow_s = 32'(ROWS - 1);
`else
          offBoard_s = 1'b1;
`endif
        end else begin
          nextRow_s = oRow - 32'd1;
        end
      end
      default: begin
        nextRow_s  = oRow;
        nextCol_s  = oCol;
        offBoard_s = 1'b0;
      end
    endcase
    nextPos_s = nextRow_s * 32'(COLS) + nextCol_s;
  end

  // Game FSM: tick counter, direction commit and head movement.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_r        <= IDLE;
      tickCnt_r      <= {TW{1'b0}};
      pending_r      <= DIR_RIGHT;
      oDir           <= DIR_RIGHT;
      oRow           <= ROW_HOME;
      oCol           <= COL_HOME;
      oBoardPosition <= POS_HOME;
      oStep          <= 1'b0;
      oDead          <= 1'b0;
    end else begin
      oStep <= 1'b0;
      case (state_r)
        IDLE: begin
          tickCnt_r <= {TW{1'b0}};
          if (accept_s) begin
            pending_r <= pressDir_s;
            state_r   <= RUN;
          end
        end
        RUN: begin
          // A press in the tick cycle lands in pending_r after the old value commits.
          if (accept_s) begin
            pending_r <= pressDir_s;
          end
          if (tick_s) begin
            tickCnt_r <= {TW{1'b0}};
            oDir      <= pending_r;
            if (offBoard_s) begin
              state_r <= DEAD;
              oDead   <= 1'b1;
            end else begin
              oRow           <= nextRow_s;
              oCol           <= nextCol_s;
              oBoardPosition <= nextPos_s;
              oStep          <= 1'b1;
            end
          end else begin
            tickCnt_r <= tickCnt_r + TW'(1);
          end
        end
        DEAD: begin
          tickCnt_r <= {TW{1'b0}};
          oDead     <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          tickCnt_r <= {TW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Directed self-checking bench for snake_head_stepper (COLS=8, ROWS=6, TICK_DIV=4, DEB_CYCLES=2).
// Expectations follow SNAKE_WRAP_EN the same way the design build does.
module tb_snake_head_stepper;

  logic        clk = 1'b0;
  logic        rstN;
  logic        up, down, left, right;
  logic [31:0] oRow, oCol, oPos;
  logic [1:0]  oDir;
  logic        oStep, oDead;

  int   checkCnt = 0;
  int   errCnt   = 0;
  int   n;
  int   s;
  logic hit;

  always #5 clk = ~clk;

  snake_head_stepper #(
    .COLS(8), .ROWS(6), .TICK_DIV(4), .DEB_CYCLES(2)
  ) dut (
    .iVGA_CLK(clk), .iRST_n(rstN),
    .up(up), .down(down), .left(left), .right(right),
    .oRow(oRow), .oCol(oCol), .oBoardPosition(oPos),
    .oDir(oDir), .oStep(oStep), .oDead(oDead)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitMove(input int budget, output int cnt, output logic seen);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < budget) begin
      @(posedge clk);
      #1;
      cnt++;
      if (oStep || oDead) seen = 1'b1;
    end
  endtask

  task automatic quiet(input int k, output int steps);
    steps = 0;
    repeat (k) begin
      @(posedge clk);
      #1;
      if (oStep) steps++;
    end
  endtask

  task automatic checkHome(input string tag);
    checkVal({tag, "_row"},  oRow,  32'd3);
    checkVal({tag, "_col"},  oCol,  32'd4);
    checkVal({tag, "_pos"},  oPos,  32'd28);
    checkVal({tag, "_dir"},  {30'd0, oDir}, 32'd0);
    checkVal({tag, "_step"}, {31'd0, oStep}, 32'd0);
    checkVal({tag, "_dead"}, {31'd0, oDead}, 32'd0);
  endtask

  task automatic checkMove(input string tag, input int r, input int c, input int d, input int period);
    int   k;
    logic got;
    waitMove(40, k, got);
    checkVal({tag, "_seen"}, {31'd0, got}, 32'd1);
    if (period >= 0) checkVal({tag, "_period"}, k, period);
    checkVal({tag, "_step"}, {31'd0, oStep}, 32'd1);
    checkVal({tag, "_row"},  oRow, r);
    checkVal({tag, "_col"},  oCol, c);
    checkVal({tag, "_pos"},  oPos, r * 8 + c);
    checkVal({tag, "_dir"},  {30'd0, oDir}, d);
    checkVal({tag, "_dead"}, {31'd0, oDead}, 32'd0);
  endtask

  initial begin
    rstN = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    cycles(3);
    rstN = 1'b1;
    checkHome("reset");

    // Left is opposite to the reset direction: stays idle.
    left = 1'b1;
    cycles(6);
    left = 1'b0;
    quiet(12, s);
    checkVal("idleLeft_steps", s, 0);
    checkHome("idleLeft");

    // Run right to the east edge.
    right = 1'b1;
    checkMove("runA1", 3, 5, 0, -1);
    right = 1'b0;
    checkMove("runA2", 3, 6, 0, 4);
    checkMove("runA3", 3, 7, 0, 4);
`ifdef SNAKE_WRAP_EN
    checkMove("wrapCol", 3, 0, 0, 4);
`else
    waitMove(40, n, hit);
    checkVal("deadCol_seen", {31'd0, hit}, 32'd1);
    checkVal("deadCol_period", n, 4);
    checkVal("deadCol_dead", {31'd0, oDead}, 32'd1);
    checkVal("deadCol_step", {31'd0, oStep}, 32'd0);
    checkVal("deadCol_col", oCol, 32'd7);
    checkVal("deadCol_pos", oPos, 32'd31);
    down = 1'b1;
    quiet(12, s);
    down = 1'b0;
    checkVal("deadHold_steps", s, 0);
    checkVal("deadHold_dead", {31'd0, oDead}, 32'd1);
    checkVal("deadHold_row", oRow, 32'd3);
    checkVal("deadHold_col", oCol, 32'd7);
`endif

    // Mid-run reset with the tick counter at 2.
    rstN = 1'b0;
    cycles(2);
    rstN = 1'b1;
    checkHome("resetB");
    right = 1'b1;
    checkMove("runB1", 3, 5, 0, -1);
    right = 1'b0;
    cycles(2);
    rstN = 1'b0;
    cycles(1);
    rstN = 1'b1;
    checkHome("midReset");
    quiet(12, s);
    checkVal("midReset_steps", s, 0);
    checkVal("midReset_col", oCol, 32'd4);

    // Opposite press ignored while running, then turn up.
    right = 1'b1;
    checkMove("runC1", 3, 5, 0, -1);
    right = 1'b0;
    left = 1'b1;
    checkMove("leftIgnored", 3, 6, 0, 4);
    left = 1'b0;
    up = 1'b1;
    checkMove("preUp", 3, 7, 0, 4);
    up = 1'b0;
    checkMove("upTurn", 2, 7, 3, 4);

    // Bounce rejection, then up beats left.
    rstN = 1'b0;
    cycles(2);
    rstN = 1'b1;
    repeat (6) begin
      up = 1'b1;
      cycles(1);
      up = 1'b0;
      cycles(1);
    end
    quiet(12, s);
    checkVal("bounce_steps", s, 0);
    checkHome("bounce");
    up = 1'b1;
    left = 1'b1;
    checkMove("prio", 2, 4, 3, -1);
    up = 1'b0;
    left = 1'b0;
    checkMove("up2", 1, 4, 3, 4);
    checkMove("up3", 0, 4, 3, 4);
`ifdef SNAKE_WRAP_EN
    checkMove("wrapRow", 5, 4, 3, 4);
`else
    waitMove(40, n, hit);
    checkVal("deadRow_seen", {31'd0, hit}, 32'd1);
    checkVal("deadRow_period", n, 4);
    checkVal("deadRow_dead", {31'd0, oDead}, 32'd1);
    checkVal("deadRow_step", {31'd0, oStep}, 32'd0);
    checkVal("deadRow_row", oRow, 32'd0);
    checkVal("deadRow_pos", oPos, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/snake_head_stepper.md
SNAKE_HEAD_STEPPER -- requirements
Module: snake_head_stepper

Interface
REQ-001 Parameter COLS, default 32, board width in cells.
REQ-002 Parameter ROWS, default 24, board height in cells.
REQ-003 Parameter TICK_DIV, default 5000000, clock cycles per game step (>=2).
REQ-004 Parameter DEB_CYCLES, default 250000, cycles a button level must be stable to be accepted (>=1).
REQ-005 iVGA_CLK  input  1  sole clock; all state SHALL change only on its rising edge.
REQ-006 iRST_n  input  1  reset, synchronous, active-low.
REQ-007 up, down, left, right  input  1 each  raw asynchronous push-button levels, active-high.
REQ-008 oRow  output  32  head row, 0..ROWS-1.
REQ-009 oCol  output  32  head column, 0..COLS-1.
REQ-010 oBoardPosition  output  32  oRow*COLS+oCol, feeds the display controller's boardPosition.
REQ-011 oDir  output  2  committed direction: 00 right, 01 down, 10 left, 11 up.
REQ-012 oStep  output  1  one-cycle pulse in the cycle after the head moved.
REQ-013 oDead  output  1  high while in DEAD state.

Function
REQ-014 Each button SHALL pass a two-flop synchronizer, then a per-button debounce counter; debounced level changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-015 A press SHALL be a one-cycle pulse on the debounced 0->1 edge; holding a button SHALL produce no further presses.
REQ-016 Simultaneous presses SHALL resolve by priority up > down > left > right; lower-priority ones are discarded.
REQ-017 A press opposite to the committed oDir SHALL be ignored; a press equal to oDir is accepted without effect.
REQ-018 An accepted press SHALL overwrite the pending direction; the last accepted press before a tick wins.
REQ-019 FSM states IDLE, RUN, DEAD; IDLE->RUN on first accepted press (opposite rule applies against reset direction), RUN->DEAD per REQ-030, DEAD exits only by reset.
REQ-020 Tick counter SHALL count 0..TICK_DIV-1 and wrap only in RUN; it SHALL be held at 0 in IDLE and DEAD.
REQ-021 On the cycle the counter equals TICK_DIV-1 (tick), pending direction SHALL be committed to oDir and the head moved one cell in that direction, all registered at the same edge.
REQ-022 oRow, oCol, oBoardPosition, oDir and oStep SHALL all update at that same edge (one-cycle latency from tick); oBoardPosition SHALL never be inconsistent with oRow/oCol.
REQ-023 oBoardPosition arithmetic SHALL be 32-bit unsigned, no truncation for ROWS*COLS < 2^31.
REQ-024 A press arriving in the tick cycle SHALL be pending for the next tick, not the current one.
REQ-025 oStep SHALL be 0 in all cycles other than the one following a move.

Reset
REQ-026 While iRST_n=0 at a rising edge: oRow=ROWS/2, oCol=COLS/2, oBoardPosition=(ROWS/2)*COLS+COLS/2, oDir=00, pending=00, state IDLE, tick counter 0, oStep=0, oDead=0, synchronizers and debounced levels 0, debounce counters 0.
REQ-027 Reset asserted mid-operation (any state, any counter value) SHALL take effect on the next edge with no residual press or step.

Configuration
REQ-028 Macro SNAKE_WRAP_EN selects edge behaviour.
REQ-029 With SNAKE_WRAP_EN defined: a move past col COLS-1 SHALL go to 0, below 0 to COLS-1; rows likewise with ROWS; oDead never asserts.
REQ-030 Without it: a move that would leave the board SHALL leave oRow/oCol unchanged, assert no oStep, and enter DEAD (oDead=1 at the same edge).

Verification
REQ-031 Bench params COLS=8, ROWS=6, TICK_DIV=4, DEB_CYCLES=2; reset -> oRow=3, oCol=4, oBoardPosition=28, oDir=00, oDead=0.
REQ-032 Press right (held 10 cycles) -> RUN; each 4 cycles oStep pulses, oCol 5,6,7; oBoardPosition 29,30,31.
REQ-033 From oDir=00 press left -> ignored, oDir stays 00; then press up -> next step oRow=2, oDir=11.
REQ-034 Button bouncing 1-cycle pulses -> no press; up and left pressed same cycle -> up accepted.
REQ-035 At oCol=7 moving right: with SNAKE_WRAP_EN -> oCol=0, oBoardPosition=24; without -> oCol stays 7, oDead=1, no oStep, counter frozen.
REQ-036 iRST_n low for one cycle in RUN with counter at 2 -> all outputs at REQ-026 values next edge, state IDLE.
